arbitro_alu: RTL and testbench

- Shares one combinational ALU instance (operandos `ancho+1` bits, 4-bit seleccion, 4-bit banderas) between two requesters.
- Round-robin arbitration, registered operand issue, result/flag capture, and per-requester response handshake.
- Rejects illegal selection codes and division/modulo by zero without issuing them.
- Sits between the two datapath clients and the ALU; the ALU itself is instantiated outside this block.

---
 rtl/arbitro_alu.sv | 235 +++++++++++++++++++++++
 tb/tb_arbitro_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_alu.sv
// arbitro_alu: shares one external combinational ALU between two requesters.
//
// A round-robin grant is issued only while idle (REPOSO). The accepted
// operation is checked for legality; legal ones are issued to the ALU through
// registered alu_* outputs and the result is captured one cycle later
// (EJECUTA). Illegal selections and division/modulo by zero are answered
// directly with an error response, and the ALU registers are left untouched.
// The response is held (RESPONDE) until the granted requester takes it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester request handshake (bit i = requester i)
//   req_operandoA/B          packed operands, requester i at [i*(ancho+1) +: ancho+1]
//   req_seleccion            packed selection codes, requester i at [i*4 +: 4]
//   rsp_valid/rsp_ready      per-requester response handshake, rsp_valid one-hot
//   rsp_resultado/banderas   captured ALU result and flags
//   rsp_error                operation was rejected
//   alu_operandoA/B, alu_seleccion   registered operation issued to the ALU
//   alu_resultado/banderas   combinational answer from the ALU
//   ocupado                  FSM is not idle
//   contador_operaciones     completed responses, saturating
module arbitro_alu #(
  parameter int ancho          = 3,
  parameter int ancho_contador = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [2*(ancho+1)-1:0]      req_operandoA,
  input  logic [2*(ancho+1)-1:0]      req_operandoB,
  input  logic [7:0]                  req_seleccion,
  output logic [1:0]                  rsp_valid,
  input  logic [1:0]                  rsp_ready,
  output logic [ancho:0]              rsp_resultado,
  output logic [3:0]                  rsp_banderas,
  output logic                        rsp_error,
  output logic [ancho:0]              alu_operandoA,
  output logic [ancho:0]              alu_operandoB,
  output logic [3:0]                  alu_seleccion,
  input  logic [ancho:0]              alu_resultado,
  input  logic [3:0]                  alu_banderas,
  output logic                        ocupado,
  output logic [ancho_contador:0]     contador_operaciones
);

  localparam int W  = ancho + 1;
  localparam int CW = ancho_contador + 1;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    EJECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  // Codes 0..9 are implemented; division (3) and modulo (4) also need a
  // non-zero divisor.
  function automatic logic op_legal(input logic [3:0] sel, input logic [W-1:0] b);
    logic ok;
    ok = (sel <= 4'd9);
    if (((sel == 4'd3) || (sel == 4'd4)) && (b == {W{1'b0}})) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  estado_t         estado_q, estado_d;
  logic            puntero_q, puntero_d;   // requester favoured on contention
  logic            concedido_q, concedido_d; // requester being served
  logic [W-1:0]    alu_a_q, alu_a_d;
  logic [W-1:0]    alu_b_q, alu_b_d;
  logic [3:0]      alu_sel_q, alu_sel_d;
  logic [W-1:0]    resultado_q, resultado_d;
  logic [3:0]      banderas_q, banderas_d;
  logic            error_q, error_d;
  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic            ocupado_q, ocupado_d;
  logic [CW-1:0]   contador_q, contador_d;

  logic            grant_valid_s;
  logic            grant_s;
  logic [1:0]      req_ready_s;
  logic            acepta_s;
  logic [W-1:0]    sel_a_s;
  logic [W-1:0]    sel_b_s;
  logic [3:0]      sel_op_s;

  // Round-robin grant: a lone requester always wins, the pointer breaks ties.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_s       = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_s       = puntero_q;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_s       = 1'b0;
      end
    endcase
  end

  // Ready only while idle and out of reset, so every output reads 0 in reset.
  always_comb begin
    req_ready_s = 2'b00;
    if (!rst && (estado_q == REPOSO) && grant_valid_s) begin
      req_ready_s = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign acepta_s  = |(req_valid & req_ready_s);
  assign sel_a_s   = grant_s ? req_operandoA[2*W-1:W] : req_operandoA[W-1:0];
  assign sel_b_s   = grant_s ? req_operandoB[2*W-1:W] : req_operandoB[W-1:0];
  assign sel_op_s  = grant_s ? req_seleccion[7:4]     : req_seleccion[3:0];

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    estado_d    = estado_q;
    puntero_d   = puntero_q;
    concedido_d = concedido_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    resultado_d = resultado_q;
    banderas_d  = banderas_q;
    error_d     = error_q;
    rsp_valid_d = rsp_valid_q;
    contador_d  = contador_q;
    case (estado_q)
      REPOSO: begin
        if (acepta_s) begin
          concedido_d = grant_s;
          if (op_legal(sel_op_s, sel_b_s)) begin
            alu_a_d   = sel_a_s;
            alu_b_d   = sel_b_s;
            alu_sel_d = sel_op_s;
            estado_d  = EJECUTA;
          end else begin
            // Rejected: answer immediately, ALU registers keep their values.
            resultado_d = {W{1'b0}};
            banderas_d  = 4'd0;
            error_d     = 1'b1;
            rsp_valid_d = grant_s ? 2'b10 : 2'b01;
            estado_d    = RESPONDE;
          end
        end else begin
          estado_d = REPOSO;
        end
      end
      EJECUTA: begin
        resultado_d = alu_resultado;
        banderas_d  = alu_banderas;
        error_d     = 1'b0;
        rsp_valid_d = concedido_q ? 2'b10 : 2'b01;
        estado_d    = RESPONDE;
      end
      RESPONDE: begin
        if (rsp_ready[concedido_q]) begin
          if (contador_q == {CW{1'b1}}) begin
            contador_d = contador_q;
          end else begin
            contador_d = contador_q + {{(CW-1){1'b0}}, 1'b1};
          end
          // Pointer always passes to the other requester after service.
          puntero_d   = ~concedido_q;
          rsp_valid_d = 2'b00;
          estado_d    = REPOSO;
        end else begin
          estado_d = RESPONDE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        estado_d    = REPOSO;
      end
    endcase
    ocupado_d = (estado_d != REPOSO);
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q    <= REPOSO;
      puntero_q   <= 1'b0;
      concedido_q <= 1'b0;
      alu_a_q     <= {W{1'b0}};
      alu_b_q     <= {W{1'b0}};
      alu_sel_q   <= 4'd0;
      resultado_q <= {W{1'b0}};
      banderas_q  <= 4'd0;
      error_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      ocupado_q   <= 1'b0;
      contador_q  <= {CW{1'b0}};
    end else begin
      estado_q    <= estado_d;
      puntero_q   <= puntero_d;
      concedido_q <= concedido_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      resultado_q <= resultado_d;
      banderas_q  <= banderas_d;
      error_q     <= error_d;
      rsp_valid_q <= rsp_valid_d;
      ocupado_q   <= ocupado_d;
      contador_q  <= contador_d;
    end
  end

  assign req_ready            = req_ready_s;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_resultado        = resultado_q;
  assign rsp_banderas         = banderas_q;
  assign rsp_error            = error_q;
  assign alu_operandoA        = alu_a_q;
  assign alu_operandoB        = alu_b_q;
  assign alu_seleccion        = alu_sel_q;
  assign ocupado              = ocupado_q;
  assign contador_operaciones = contador_q;

endmodule

// File: tb/tb_arbitro_alu.sv
// Directed self-checking bench for arbitro_alu. A second instance with a
// 2-bit counter shares all stimulus and is used for counter saturation.
module tb_arbitro_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [7:0]  opa = 8'h00;
  logic [7:0]  opb = 8'h00;
  logic [7:0]  sel = 8'h00;

  logic [1:0]  req_ready, rsp_valid;
  logic [3:0]  rsp_resultado, rsp_banderas;
  logic        rsp_error, ocupado;
  logic [3:0]  alu_a, alu_b, alu_sel, alu_res, alu_fl;
  logic [15:0] contador;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [3:0]  s_rsp_resultado, s_rsp_banderas;
  logic        s_rsp_error, s_ocupado;
  logic [3:0]  s_alu_a, s_alu_b, s_alu_sel, s_alu_res, s_alu_fl;
  logic [1:0]  s_contador;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Reference ALU of the environment: flags = {0, negative, carry/borrow, zero}.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    logic [4:0] t;
    logic [3:0] r;
    logic       c;
    t = 5'd0;
    c = 1'b0;
    case (s)
      4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[3:0]; c = t[4]; end
      4'd1: begin t = {1'b0, a} - {1'b0, b}; r = t[3:0]; c = t[4]; end
      4'd2: r = a * b;
      4'd3: r = (b != 4'd0) ? a / b : 4'd0;
      4'd4: r = (b != 4'd0) ? a % b : 4'd0;
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = a << 1;
      4'd9: r = a >> 1;
      default: r = 4'd0;
    endcase
    return {1'b0, r[3], c, (r == 4'd0), r};
  endfunction

  assign {alu_fl, alu_res}     = alu_f(alu_a, alu_b, alu_sel);
  assign {s_alu_fl, s_alu_res} = alu_f(s_alu_a, s_alu_b, s_alu_sel);

  arbitro_alu #(.ancho(3), .ancho_contador(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operandoA(opa), .req_operandoB(opb), .req_seleccion(sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resultado(rsp_resultado), .rsp_banderas(rsp_banderas), .rsp_error(rsp_error),
    .alu_operandoA(alu_a), .alu_operandoB(alu_b), .alu_seleccion(alu_sel),
    .alu_resultado(alu_res), .alu_banderas(alu_fl),
    .ocupado(ocupado), .contador_operaciones(contador)
  );

  arbitro_alu #(.ancho(3), .ancho_contador(1)) dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(s_req_ready),
    .req_operandoA(opa), .req_operandoB(opb), .req_seleccion(sel),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resultado(s_rsp_resultado), .rsp_banderas(s_rsp_banderas), .rsp_error(s_rsp_error),
    .alu_operandoA(s_alu_a), .alu_operandoB(s_alu_b), .alu_seleccion(s_alu_sel),
    .alu_resultado(s_alu_res), .alu_banderas(s_alu_fl),
    .ocupado(s_ocupado), .contador_operaciones(s_contador)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    opa[idx*4 +: 4] = a;
    opb[idx*4 +: 4] = b;
    sel[idx*4 +: 4] = s;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_ocupado", ocupado, 1'b0);
    chk("rst_contador", contador, 16'd0);
    chk("rst_alu_a", alu_a, 4'd0);
    chk("rst_req_ready", req_ready, 2'b00);
    rst = 1'b0;
    step();

    // Single operation: requester 0, 3 + 4
    set_req(0, 4'd3, 4'd4, 4'd0);
    req_valid = 2'b01;
    #1;
    chk("op1_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("op1_n1_rsp_valid", rsp_valid, 2'b00);
    chk("op1_n1_ocupado", ocupado, 1'b1);
    chk("op1_alu_a", alu_a, 4'd3);
    chk("op1_alu_b", alu_b, 4'd4);
    chk("op1_alu_sel", alu_sel, 4'd0);
    step();
    chk("op1_n2_rsp_valid", rsp_valid, 2'b01);
    chk("op1_resultado", rsp_resultado, 4'd7);
    chk("op1_banderas", rsp_banderas, 4'd0);
    chk("op1_error", rsp_error, 1'b0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("op1_rsp_drop", rsp_valid, 2'b00);
    chk("op1_contador", contador, 16'd1);
    chk("op1_ocupado", ocupado, 1'b0);

    // Reset while in EJECUTA (requester 1, 5 - 2)
    set_req(1, 4'd5, 4'd2, 4'd1);
    req_valid = 2'b10;
    #1;
    chk("rm_req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("rm_ejecuta_ocupado", ocupado, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rm_ocupado", ocupado, 1'b0);
    chk("rm_rsp_valid", rsp_valid, 2'b00);
    chk("rm_contador", contador, 16'd0);
    chk("rm_alu_a", alu_a, 4'd0);
    chk("rm_alu_sel", alu_sel, 4'd0);
    chk("rm_sat_contador", s_contador, 2'd0);
    step();
    #2;
    rst = 1'b0;
    step();
    chk("rm_after1_rsp_valid", rsp_valid, 2'b00);
    step();
    chk("rm_after2_rsp_valid", rsp_valid, 2'b00);
    chk("rm_after2_ocupado", ocupado, 1'b0);

    // Contention after reset: requester 0 first (6 & 3), then 1 (C & A)
    set_req(0, 4'h6, 4'h3, 4'd5);
    set_req(1, 4'hC, 4'hA, 4'd5);
    req_valid = 2'b11;
    #1;
    chk("ct_req_ready0", req_ready, 2'b01);
    step();
    chk("ct_busy_req_ready", req_ready, 2'b00);
    chk("ct_alu_a0", alu_a, 4'h6);
    step();
    chk("ct_rsp_valid0", rsp_valid, 2'b01);
    chk("ct_resultado0", rsp_resultado, 4'h2);
    chk("ct_banderas0", rsp_banderas, 4'h0);
    rsp_ready = 2'b10;
    step();
    chk("ct_wrongbit_rsp_valid", rsp_valid, 2'b01);
    chk("ct_wrongbit_contador", contador, 16'd0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("ct_rsp_drop0", rsp_valid, 2'b00);
    chk("ct_contador0", contador, 16'd1);
    chk("ct_sat_contador0", s_contador, 2'd1);
    chk("ct_req_ready1", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("ct_alu_a1", alu_a, 4'hC);
    chk("ct_alu_b1", alu_b, 4'hA);
    step();
    chk("ct_rsp_valid1", rsp_valid, 2'b10);
    chk("ct_resultado1", rsp_resultado, 4'h8);
    chk("ct_banderas1", rsp_banderas, 4'h4);
    chk("ct_error1", rsp_error, 1'b0);

    // Backpressure on requester 1; rsp_ready[0] and a new request are ignored
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_rsp_valid", rsp_valid, 2'b10);
      chk("bp_resultado", rsp_resultado, 4'h8);
      chk("bp_banderas", rsp_banderas, 4'h4);
      chk("bp_req_ready", req_ready, 2'b00);
    end
    rsp_ready = 2'b10;
    req_valid = 2'b00;
    step();
    rsp_ready = 2'b00;
    chk("bp_rsp_drop", rsp_valid, 2'b00);
    chk("bp_contador", contador, 16'd2);
    chk("bp_sat_contador", s_contador, 2'd2);
    req_valid = 2'b11;
    #1;
    chk("ptr_back_to_0", req_ready, 2'b01);
    req_valid = 2'b00;
    #1;

    // Rejected: illegal selection 0xB from requester 0
    step();
    set_req(0, 4'd1, 4'd1, 4'hB);
    req_valid = 2'b01;
    #1;
    chk("rj1_req_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("rj1_rsp_valid", rsp_valid, 2'b01);
    chk("rj1_resultado", rsp_resultado, 4'd0);
    chk("rj1_banderas", rsp_banderas, 4'd0);
    chk("rj1_error", rsp_error, 1'b1);
    chk("rj1_alu_a_kept", alu_a, 4'hC);
    chk("rj1_alu_sel_kept", alu_sel, 4'd5);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("rj1_contador", contador, 16'd3);
    chk("rj1_sat_contador", s_contador, 2'd3);

    // Rejected: division by zero from requester 1
    set_req(1, 4'd7, 4'd0, 4'd3);
    req_valid = 2'b10;
    #1;
    chk("rj2_req_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b00;
    chk("rj2_rsp_valid", rsp_valid, 2'b10);
    chk("rj2_error", rsp_error, 1'b1);
    chk("rj2_resultado", rsp_resultado, 4'd0);
    chk("rj2_alu_b_kept", alu_b, 4'hA);
    chk("rj2_alu_sel_kept", alu_sel, 4'd5);
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
    chk("rj2_contador", contador, 16'd4);
    chk("rj2_sat_contador", s_contador, 2'd3);

    // Legal subtraction with borrow: 2 - 5 = 0xD
    set_req(0, 4'd2, 4'd5, 4'd1);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("sub_n1_rsp_valid", rsp_valid, 2'b00);
    step();
    chk("sub_rsp_valid", rsp_valid, 2'b01);
    chk("sub_resultado", rsp_resultado, 4'hD);
    chk("sub_banderas", rsp_banderas, 4'h6);
    chk("sub_error", rsp_error, 1'b0);
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    chk("sub_contador", contador, 16'd5);
    chk("sub_sat_contador", s_contador, 2'd3);
    chk("sub_alu_sel_hold", alu_sel, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
